display_scanner: RTL
====================

Name: display_scanner

Overview:
- Time-multiplexing stage directly upstream of the 7-segment decoder on the Basys3 4-digit display.
- Takes four BCD digits from the clock datapath; cycles a 2-bit digit index at a fixed refresh rate; presents one nibble plus index per slot to the decoder.
- Snapshots the digit word once per frame so a display frame never mixes old and new time values. Provides per-digit blanking and leading-zero suppression.

Parameters:
- PRESCALE, 100000, clk cycles per digit slot (1 ms at 100 MHz); legal range >= 1.
- BLINK_FRAMES, 125, frames per blink half-period (only used with BLINK_EN; 125 x 4 ms = 0.5 s).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- digits  in  16  four BCD nibbles: [15:12] leftmost digit (index 0) through [3:0] rightmost digit (index 3).
- blank_mask  in  4  bit i=1 blanks digit index i (bit 0 = leftmost).
- lz_en  in  1  leading-zero suppression of index 0.
- en  out  2  digit index to decoder: 0 = leftmost (anode 0111) through 3 = rightmost (anode 1110).
- num  out  4  nibble for the current index.
- blank  out  1  1 = force all anodes off for this slot (top level gates anode_active with it).
- frame_tick  out  1  one-cycle pulse on the edge en wraps 3->0.
- blink_mask  in  4  (BLINK_EN only) bit i=1 blinks digit index i.

Behaviour:
- Reset (rst_n=0 at rising edge): prescale counter=0, en=0, num=0, blank=1, frame_tick=0, snapshot registers=0, load flag=1; blink phase and frame counter=0 (BLINK_EN). Reset mid-slot aborts the slot immediately; no partial state survives.
- Load flag: on the first cycle after reset release, snapshot <= digits, mask <= blank_mask; en=0; num/blank updated from the new capture on the same edge; load flag cleared. The prescale counter starts counting on this cycle.
- Prescaler counts 0..PRESCALE-1. On the count = PRESCALE-1 edge: counter -> 0, en <= en+1 mod 4. With PRESCALE=1, en advances every cycle.
- Frame wrap (en 3->0 edge): snapshot <= digits, mask <= blank_mask on the same edge; frame_tick=1 for exactly that cycle; num/blank for index 0 come from the newly captured values, with no one-frame lag.
- en, num, and blank are all registered and change on the same edge; they are never skewed by a cycle.
- num = snapshot nibble for next index. Values 10-15 are passed through unchanged; the decoder handles them.
- blank = mask[idx] OR (lz_en AND idx==0 AND nibble==0) OR blink term. lz_en is sampled live, not snapshotted.
- digits and blank_mask changes mid-frame are ignored until the next wrap.
- Steady state: each index is held for exactly PRESCALE cycles. Frame = 4*PRESCALE cycles.

Optional Feature:
- Macro: DISPLAY_SCANNER_BLINK_EN.
- Defined: blink_mask port exists. Frame counter counts frame_ticks 0..BLINK_FRAMES-1. On wrap it toggles blink_phase and returns to 0. Blink term = blink_phase AND blink_mask[idx]. blink_mask is snapshotted at frame wrap like blank_mask. blink_phase starts at 0 (visible) after reset.
- Undefined: no blink_mask port, no frame counter; blink term = 0.

Test Plan (PRESCALE=4, BLINK_FRAMES=2):
- Reset release with digits=16'h1234, mask=0, lz_en=0 -> en=0,num=1,blank=0 on first cycle; en steps 0,1,2,3 every 4 cycles with num 1,2,3,4; frame_tick high only on the 3->0 edge (cycle 16).
- digits changed 1234->5678 while en=1 -> en=2,3 still show 3,4; on wrap en=0 shows num=5 on the same edge.
- blank_mask=4'b0100 -> blank=1 only while en=2; all other slots blank=0.
- digits=16'h0945, lz_en=1 -> blank=1 at en=0; en=1 shows num=9, blank=0. lz_en=0 -> en=0 shows num=0, blank=0.
- rst_n pulsed low at prescale count 2 of en=2 -> next edge en=0,num=0,blank=1,frame_tick=0; normal scan resumes from index 0 after release.
- BLINK_EN defined, blink_mask=4'b0001 -> index 0 visible for 2 frames, blanked for 2 frames, repeating; indices 1-3 never blanked.

Source files
------------

// File: rtl/display_scanner_if.sv
// Scanner bus: the BCD digit word and display controls in; index, nibble and blank out to the decoder.
// DISPLAY_SCANNER_BLINK_EN adds the per-digit blink_mask.
interface display_scanner_if;
    logic [15:0] digits;
    logic [3:0]  blank_mask;
    logic        lz_en;
`ifdef DISPLAY_SCANNER_BLINK_EN
    logic [3:0]  blink_mask;
`endif
    logic [1:0]  en;
    logic [3:0]  num;
    logic        blank;
    logic        frame_tick;

    modport master (
        output digits, blank_mask, lz_en,
`ifdef DISPLAY_SCANNER_BLINK_EN
        output blink_mask,
`endif
        input  en, num, blank, frame_tick
    );

    modport slave (
        input  digits, blank_mask, lz_en,
`ifdef DISPLAY_SCANNER_BLINK_EN
        input  blink_mask,
`endif
        output en, num, blank, frame_tick
    );
endinterface

// File: rtl/display_scanner.sv
// Purpose: 4-digit display time-multiplexer with a per-frame snapshot, blanking and leading-zero suppression (blink via DISPLAY_SCANNER_BLINK_EN).
// Latency: en/num/blank are registered and change together; a new digit word appears at the first frame wrap after it is presented.
// Backpressure: none; the scan free-runs at one slot every PRESCALE cycles.
module display_scanner #(
    parameter int PRESCALE     = 100000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic              clk,
    input  logic              rst_n,
    display_scanner_if.slave  bus
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0] cnt;
    logic [15:0]   snap;
    logic [3:0]    mask;
    logic          load;

    logic          slot_end;
    logic          wrap;
    logic          capture;
    logic [1:0]    idx_nxt;
    logic [15:0]   digits_src;
    logic [3:0]    mask_src;
    logic [3:0]    nib_nxt;
    logic          blink_term;
    logic          blank_nxt;

    assign slot_end = (cnt == CW'(PRESCALE - 1));
    assign wrap     = !load && slot_end && (bus.en == 2'd3);
    assign capture  = load || wrap;
    assign idx_nxt  = load ? 2'd0 : bus.en + 2'd1;

    // At a capture edge the slot for index 0 is built straight from the live inputs.
    assign digits_src = capture ? bus.digits     : snap;
    assign mask_src   = capture ? bus.blank_mask : mask;

    always_comb begin
        nib_nxt = 4'd0;
        case (idx_nxt)
            2'd0: nib_nxt = digits_src[15:12];
            2'd1: nib_nxt = digits_src[11:8];
            2'd2: nib_nxt = digits_src[7:4];
            2'd3: nib_nxt = digits_src[3:0];
            default: nib_nxt = 4'd0;
        endcase
    end

`ifdef DISPLAY_SCANNER_BLINK_EN
    logic [3:0]    bmask;
    logic          phase;
    logic [FW-1:0] fcnt;
    logic          fcnt_end;
    logic          phase_nxt;
    logic [3:0]    bmask_src;

    assign fcnt_end   = (fcnt == FW'(BLINK_FRAMES - 1));
    // The slot opened by a wrap must already see the toggled phase.
    assign phase_nxt  = (wrap && fcnt_end) ? ~phase : phase;
    assign bmask_src  = capture ? bus.blink_mask : bmask;
    assign blink_term = phase_nxt & bmask_src[idx_nxt];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bmask <= 4'd0;
            phase <= 1'b0;
            fcnt  <= '0;
        end else begin
            if (capture) bmask <= bus.blink_mask;
            if (wrap) begin
                phase <= phase_nxt;
                fcnt  <= fcnt_end ? '0 : fcnt + FW'(1);
            end
        end
    end
`else
    assign blink_term = 1'b0;
`endif

    assign blank_nxt = mask_src[idx_nxt]
                     | (bus.lz_en && (idx_nxt == 2'd0) && (nib_nxt == 4'd0))
                     | blink_term;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt            <= '0;
            bus.en         <= 2'd0;
            bus.num        <= 4'd0;
            bus.blank      <= 1'b1;
            bus.frame_tick <= 1'b0;
            snap           <= 16'd0;
            mask           <= 4'd0;
            load           <= 1'b1;
        end else begin
            load           <= 1'b0;
            bus.frame_tick <= wrap;
            if (load || slot_end) cnt <= '0;
            else                  cnt <= cnt + CW'(1);
            if (capture) begin
                snap <= bus.digits;
                mask <= bus.blank_mask;
            end
            if (load || slot_end) begin
                bus.en    <= idx_nxt;
                bus.num   <= nib_nxt;
                bus.blank <= blank_nxt;
            end
        end
    end
endmodule
